// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

   localparam int BYTE_WIDTH     = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream handshake and iram write port of the loader
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
);

   logic                  in_valid;
   logic [BYTE_WIDTH-1:0] in_byte;
   logic                  in_ready;
   logic                  ram_ena;
   logic                  ram_wena;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_indata;

   // master is the loader: it consumes the stream and drives the RAM port
   modport master (
      input  in_valid, in_byte,
      output in_ready, ram_ena, ram_wena, ram_addr, ram_indata
   );

   modport slave (
      output in_valid, in_byte,
      input  in_ready, ram_ena, ram_wena, ram_addr, ram_indata
   );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles a big-endian byte stream into words and writes the iram
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH:0]   word_count,
   imem_loader_if.master         bus,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE_WORD   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [1:0]          LAST_BYTE  = 2'(BYTES_PER_WORD - 1);
   localparam int                  HEAD_WIDTH = DATA_WIDTH - BYTE_WIDTH;

   state_e                state, state_nxt;
   logic [HEAD_WIDTH-1:0] head;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH:0]   remaining;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  accept;
   logic [DATA_WIDTH-1:0] word_full;

   // Only the first three bytes are kept; the fourth completes the word directly into wdata,
   // which then holds the last written word for the RAM data bus.
   assign accept    = bus.in_valid && bus.in_ready && !abort;
   assign word_full = {head, bus.in_byte};

   assign bus.ram_addr   = addr;
   assign bus.ram_indata = wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         head      <= '0;
         byte_cnt  <= '0;
         remaining <= '0;
         addr      <= '0;
         wdata     <= '0;
         checksum  <= '0;
         error     <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  remaining <= (word_count == '0) ? FULL_COUNT : word_count;
                  addr      <= '0;
                  byte_cnt  <= '0;
                  checksum  <= '0;
                  error     <= 1'b0;
               end
            end
            ST_RECV: begin
               if (abort) begin
                  error <= 1'b1;
               end else if (accept) begin
                  head     <= word_full[HEAD_WIDTH-1:0];
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == LAST_BYTE) begin
                     wdata <= word_full;
                  end
               end
            end
            ST_WRITE: begin
               if (abort) begin
                  error <= 1'b1;
               end else begin
                  checksum  <= checksum ^ wdata;
                  remaining <= remaining - ONE_WORD;
                  addr      <= addr + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      bus.in_ready = 1'b0;
      bus.ram_ena  = 1'b0;
      bus.ram_wena = 1'b0;
      cpu_hold     = 1'b1;
      done         = 1'b0;
      case (state)
         ST_IDLE: begin
            cpu_hold = 1'b0;
            if (start) begin
               state_nxt = ST_RECV;
            end
         end
         ST_RECV: begin
            bus.in_ready = 1'b1;
            if (abort) begin
               state_nxt = ST_IDLE;
            end else if (bus.in_valid && byte_cnt == LAST_BYTE) begin
               state_nxt = ST_WRITE;
            end
         end
         ST_WRITE: begin
            // abort kills the write in the same cycle so no stale word lands in the RAM
            if (abort) begin
               state_nxt = ST_IDLE;
            end else begin
               bus.ram_ena  = 1'b1;
               bus.ram_wena = 1'b1;
               state_nxt    = (remaining == ONE_WORD) ? ST_DONE : ST_RECV;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        start      = 1'b0;
   logic        abort      = 1'b0;
   logic [3:0]  word_count = 4'd0;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [31:0] checksum;

   imem_loader_if bus ();

   imem_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .word_count (word_count),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] tram [8];
   int          n_wr = 0;
   logic [7:0]  src [32];
   int          src_len = 0;
   int          done_cyc, wr_cyc, rdy_wr, rst_idx;
   logic [31:0] chk_done;
   logic        hold_done, hold_after, err_after, rdy_after;
   logic [2:0]  addr_after;
   logic [63:0] vec;
   logic [7:0]  b;

   // RAM model: captures every write the loader issues
   initial begin
      for (int i = 0; i < 8; i++) tram[i] = 32'h0;
      forever begin
         @(posedge clk);
         if (bus.ram_ena && bus.ram_wena) begin
            tram[bus.ram_addr] = bus.ram_indata;
            n_wr++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic run_load(input logic [3:0] wc, input bit gaps, input int abort_addr, input bit busy);
      int idx  = 0;
      bit stop = 1'b0;
      done_cyc = 0;
      wr_cyc   = 0;
      rdy_wr   = 0;
      @(negedge clk);
      start        = 1'b1;
      word_count   = wc;
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hEE;
      #1 check("idle_ready", bus.in_ready, 0);
      for (int cyc = 1; cyc <= 200 && !stop; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         abort = 1'b0;
         if (busy) word_count = 4'd0;
         bus.in_valid = gaps ? ((cyc % 2) == 1) : 1'b1;
         bus.in_byte  = (idx < src_len) ? src[idx] : 8'h00;
         if (busy && cyc == 2) start = 1'b1;
         #1;
         if (cyc == 1) begin
            check("hold_rise", cpu_hold, 1);
            check("err_clear", error, 0);
         end
         if (abort_addr >= 0 && bus.ram_wena && int'(bus.ram_addr) == abort_addr) begin
            abort = 1'b1;
            #1;
            check("abort_wena", bus.ram_wena, 0);
            check("abort_ena", bus.ram_ena, 0);
            stop = 1'b1;
         end
         if (bus.ram_wena) wr_cyc++;
         if (bus.ram_wena && bus.in_ready) rdy_wr++;
         if (done) begin
            done_cyc  = cyc;
            chk_done  = checksum;
            hold_done = cpu_hold;
            if (busy) start = 1'b1;
            stop = 1'b1;
         end
         if (bus.in_valid && bus.in_ready && !abort) idx++;
      end
      @(negedge clk);
      start        = 1'b0;
      abort        = 1'b0;
      bus.in_valid = 1'b0;
      word_count   = wc;
      #1;
      hold_after = cpu_hold;
      err_after  = error;
      rdy_after  = bus.in_ready;
      addr_after = bus.ram_addr;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_byte  = 8'h00;

      @(negedge clk);
      #1;
      check("rst_ready", bus.in_ready, 0);
      check("rst_ena", bus.ram_ena, 0);
      check("rst_wena", bus.ram_wena, 0);
      check("rst_addr", bus.ram_addr, 0);
      check("rst_indata", bus.ram_indata, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_checksum", checksum, 0);
      @(negedge clk);
      rst_n = 1'b1;

      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hA5;
      repeat (3) begin
         @(negedge clk);
         #1;
         check("idle_noready", bus.in_ready, 0);
         check("idle_hold", cpu_hold, 0);
      end

      for (int i = 0; i < 32; i++) src[i] = 8'(i);
      src_len = 32;
      run_load(4'd0, 1'b0, -1, 1'b0);
      check("full_done_cyc", done_cyc, 41);
      check("full_writes", wr_cyc, 8);
      check("full_ready_in_write", rdy_wr, 0);
      check("full_checksum", chk_done, 32'h0000_0000);
      check("full_hold_done", hold_done, 1);
      check("full_hold_after", hold_after, 0);
      check("full_addr_wrap", addr_after, 0);
      check("full_nwr", n_wr, 8);
      for (int i = 0; i < 8; i++) begin
         b = 8'(4 * i);
         check($sformatf("full_word%0d", i), tram[i], {b, b + 8'd1, b + 8'd2, b + 8'd3});
      end

      vec = 64'hDEAD_BEEF_1234_5678;
      for (int i = 0; i < 8; i++) src[i] = vec[63 - 8 * i -: 8];
      src_len = 8;
      run_load(4'd2, 1'b1, -1, 1'b0);
      check("part_done_cyc", done_cyc, 17);
      check("part_writes", wr_cyc, 2);
      check("part_ready_in_write", rdy_wr, 0);
      check("part_checksum", chk_done, 32'hCC99_E897);
      check("part_checksum_hold", checksum, 32'hCC99_E897);
      check("part_word0", tram[0], 32'hDEAD_BEEF);
      check("part_word1", tram[1], 32'h1234_5678);
      check("part_word2_kept", tram[2], 32'h0809_0A0B);
      check("part_addr", addr_after, 2);
      check("part_nwr", n_wr, 10);

      for (int i = 0; i < 16; i++) src[i] = 8'(8'h40 + i);
      src_len = 16;
      run_load(4'd0, 1'b0, 2, 1'b0);
      check("abort_no_done", done_cyc, 0);
      check("abort_writes", wr_cyc, 2);
      check("abort_error", err_after, 1);
      check("abort_hold", hold_after, 0);
      check("abort_ready", rdy_after, 0);
      check("abort_word1", tram[1], 32'h4445_4647);
      check("abort_word2_kept", tram[2], 32'h0809_0A0B);
      check("abort_nwr", n_wr, 12);

      vec = 64'h1122_3344_0000_0000;
      for (int i = 0; i < 4; i++) src[i] = vec[63 - 8 * i -: 8];
      src_len = 4;
      run_load(4'd1, 1'b0, -1, 1'b1);
      check("busy_done_cyc", done_cyc, 6);
      check("busy_writes", wr_cyc, 1);
      check("busy_error", err_after, 0);
      check("busy_hold_after", hold_after, 0);
      check("busy_checksum", chk_done, 32'h1122_3344);
      check("busy_word0", tram[0], 32'h1122_3344);
      check("busy_word1_kept", tram[1], 32'h4445_4647);
      check("busy_nwr", n_wr, 13);

      for (int i = 0; i < 8; i++) src[i] = 8'(8'h60 + i);
      rst_idx = 0;
      @(negedge clk);
      start        = 1'b1;
      word_count   = 4'd4;
      bus.in_valid = 1'b1;
      bus.in_byte  = 8'hEE;
      for (int cyc = 1; cyc <= 7; cyc++) begin
         @(negedge clk);
         start       = 1'b0;
         bus.in_byte = src[rst_idx];
         #1;
         if (bus.in_valid && bus.in_ready) rst_idx++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check("pre_rst_addr", bus.ram_addr, 1);
      check("pre_rst_hold", cpu_hold, 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_ready", bus.in_ready, 0);
      check("arst_ena", bus.ram_ena, 0);
      check("arst_addr", bus.ram_addr, 0);
      check("arst_indata", bus.ram_indata, 0);
      check("arst_hold", cpu_hold, 0);
      check("arst_done", done, 0);
      check("arst_error", error, 0);
      check("arst_checksum", checksum, 0);
      @(negedge clk);
      rst_n = 1'b1;
      check("arst_word0", tram[0], 32'h6061_6263);

      vec = 64'hCAFE_F00D_0000_0000;
      for (int i = 0; i < 4; i++) src[i] = vec[63 - 8 * i -: 8];
      src_len = 4;
      run_load(4'd1, 1'b0, -1, 1'b0);
      check("reload_done_cyc", done_cyc, 6);
      check("reload_word0", tram[0], 32'hCAFE_F00D);
      check("reload_word1_kept", tram[1], 32'h4445_4647);
      check("reload_checksum", chk_done, 32'hCAFE_F00D);
      check("reload_nwr", n_wr, 15);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the write side of the 8-word instruction RAM that the IF stage reads by `pc[4:2]`. Accepts a big-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them to consecutive RAM addresses from 0. It holds the CPU (`cpu_hold`) for the whole load so the IF stage never fetches a half-written program. The top level muxes the loader's RAM port onto the iram port while `cpu_hold` is high.

## Interface
- `ADDR_WIDTH`, 3: RAM word-address width (depth = 2^ADDR_WIDTH = 8 words).
- `DATA_WIDTH`, 32: RAM word width; fixed at 4 bytes.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin a load; sampled only in IDLE.
- `abort`  in  1: cancel an active load.
- `word_count`  in  ADDR_WIDTH+1: words to load, sampled with `start`; 0 means full depth.
- `in_valid`  in  1: byte available.
- `in_byte`  in  8: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `ram_ena`  out  1: RAM enable.
- `ram_wena`  out  1: RAM write enable.
- `ram_addr`  out  ADDR_WIDTH: RAM word address.
- `ram_indata`  out  DATA_WIDTH: RAM write data.
- `cpu_hold`  out  1: stall PC and pipeline; select loader onto the iram port.
- `done`  out  1: one-cycle pulse on successful completion.
- `error`  out  1: sticky; set by abort, cleared by the next accepted `start`.
- `checksum`  out  DATA_WIDTH: XOR of all words written in the current or last load.

## Operation
- States:
  - **IDLE**: no RAM access. Accepted `start` does the following at the edge, then goes to RECV:
    - latch count (0 → 2^ADDR_WIDTH);
    - clear `ram_addr`, byte counter, `checksum` and `error`;
    - set `cpu_hold`.
  - **RECV**:
    - `in_ready` = 1.
    - Each handshake (`in_valid && in_ready`) shifts the byte in: `word <= {word[23:0], in_byte}`. The first byte lands in bits 31:24.
    - On the 4th accepted byte, go to WRITE.
  - **WRITE**: exactly one cycle.
    - Outputs: `ram_ena` = `ram_wena` = 1, `ram_indata` = assembled word, `ram_addr` = current address.
    - At the edge: `checksum ^= word`, decrement the remaining count, increment `ram_addr`.
    - If the remaining count reaches 0, go to DONE; otherwise go to RECV.
  - **DONE**: one cycle. `done` = 1; `cpu_hold` drops at the end of this cycle; go to IDLE.
- `ram_ena`/`ram_wena` are 1 only in WRITE; 0 in every other state.
- `in_ready` is 0 outside RECV. Bytes offered then are not consumed.
- `start` outside IDLE is ignored.
- `abort` in RECV or WRITE has priority over all other events that cycle:
  - go to IDLE and set `error`;
  - drop `cpu_hold` at the edge;
  - suppress any WRITE in that same cycle (`ram_wena` forced 0 combinationally);
  - RAM keeps the words already written.
- `abort` in IDLE or DONE has no effect.
- Address arithmetic is modulo 2^ADDR_WIDTH. A full-depth load ends with `ram_addr` wrapped to 0, and no address is written twice.
- Reset mid-load: all registers clear immediately. The RAM keeps any partial contents. `error` is not set by reset.

## Timing
- Reset values: `in_ready` 0, `ram_ena` 0, `ram_wena` 0, `ram_addr` 0, `ram_indata` 0, `cpu_hold` 0, `done` 0, `error` 0, `checksum` 0. State is IDLE.
- `cpu_hold` rises on the edge that accepts `start`. It stays high through the DONE cycle.
- With `in_valid` held high, each word takes 5 cycles: 4 RECV + 1 WRITE.
- The WRITE cycle directly follows the edge that accepted the 4th byte.
- N words take `1 + 5N + 1` cycles from start acceptance to the end of the `done` pulse.
- `in_valid` gaps only stretch RECV; no timeout.
- `ram_indata` holds the last written word until the next WRITE or reset.
- `checksum` is final during the DONE cycle and holds until the next `start`.

## Structure
- Shared package: state encoding (IDLE, RECV, WRITE, DONE), `BYTES_PER_WORD` = 4.
- Single module, no sub-modules. The 2-bit byte counter and the word-count down-counter are inline registers.

## Test plan
- **Full load.** `word_count`=0, bytes 00..1F with `in_valid` held high.
  - Writes 0x00010203 at addr 0 through 0x1C1D1E1F at addr 7, one WRITE cycle each.
  - `done` pulses at start-acceptance + 41 cycles.
  - `checksum` = XOR of the 8 words; `ram_addr` = 0 after the load.
- **Partial load with gaps.** `word_count`=2, bytes DE AD BE EF 12 34 56 78, with `in_valid` deasserted between every byte.
  - Writes 0xDEADBEEF@0 and 0x12345678@1 only.
  - `in_ready` is 0 during the WRITE cycles.
- **Abort.** `abort` asserted in the WRITE cycle of word 3.
  - No write occurs that cycle.
  - `error`=1, `cpu_hold`=0 next cycle, no `done`.
  - A following `start` clears `error`.
- **Start while busy.** `start` pulsed during RECV and during DONE.
  - Both are ignored; the load completes normally with the original count.
- **Async reset mid-RECV.** Deassert `rst_n` after 2 bytes.
  - All outputs go to their reset values without waiting for `clk`.
  - A new load of 1 word writes 0xCAFEF00D at addr 0.
- **Handshake idle.** `in_valid`=1 while IDLE.
  - `in_ready`=0, no byte is consumed, and the first byte after `start` is captured in bits 31:24.
